// File: rtl/aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// aes_decrypt_core
//   Iterative AES-128 decryption core. One block is accepted in IDLE. The
//   forward key schedule is walked up to K10 (KEYEXP). Then ten inverse rounds
//   run while the round key is walked back down to K0 (ROUND). The result is
//   held in DONE until the consumer takes it.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    ciphertext/key present
//   in_ready   out  1    core can accept a block (IDLE only)
//   ciphertext in   128  block to decrypt, bit 127 = first byte MSB
//   key        in   128  AES-128 key, same byte order
//   out_valid  out  1    plaintext valid (DONE)
//   out_ready  in   1    consumer accepts plaintext
//   plaintext  out  128  decrypted block, zero when out_valid=0
//   busy       out  1    high in KEYEXP or ROUND
// ---------------------------------------------------------------------------
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } fsm_t;

  fsm_t         fsm_r;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   rcnt;

  logic [31:0]  kw3_rev_s;
  logic [31:0]  sw_in_s;
  logic [31:0]  sw_s;
  logic [7:0]   rcon_s;
  logic [31:0]  fw0_s, fw1_s, fw2_s, fw3_s;
  logic [127:0] rk_fwd_s;
  logic [127:0] rk_rev_s;
  logic [127:0] isb_s;
  logic [127:0] imc_s;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // ------------------------------------------------------------ key helpers
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // ---------------------------------------------------------- state helpers
  // Byte n of the block is s[r][c] with n = r + 4c, stored at bits 127-8n.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int n = 0; n < 16; n++) begin
      o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Key step: forward in KEYEXP, reverse in ROUND. Both directions share one SubWord.
  always_comb begin
    kw3_rev_s = rk_reg[31:0] ^ rk_reg[63:32];
    if (fsm_r == ROUND) begin
      sw_in_s = kw3_rev_s;
      rcon_s  = rcon(rcnt);
    end else begin
      sw_in_s = rk_reg[31:0];
      rcon_s  = rcon(rcnt + 4'd1);
    end
    sw_s     = sub_rot_word(sw_in_s) ^ {rcon_s, 24'h000000};
    fw0_s    = rk_reg[127:96] ^ sw_s;
    fw1_s    = rk_reg[95:64] ^ fw0_s;
    fw2_s    = rk_reg[63:32] ^ fw1_s;
    fw3_s    = rk_reg[31:0] ^ fw2_s;
    rk_fwd_s = {fw0_s, fw1_s, fw2_s, fw3_s};
    rk_rev_s = {rk_reg[127:96] ^ sw_s,
                rk_reg[95:64] ^ rk_reg[127:96],
                rk_reg[63:32] ^ rk_reg[95:64],
                kw3_rev_s};
  end

  // Single inverse-round datapath. The reverse-stepped key K(rcnt-1) is added before InvMixColumns.
  always_comb begin
    isb_s = inv_sub_bytes(inv_shift_rows(state_reg)) ^ rk_rev_s;
    imc_s = inv_mix_columns(isb_s);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r     <= IDLE;
      state_reg <= 128'h0;
      rk_reg    <= 128'h0;
      rcnt      <= 4'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      plaintext <= 128'h0;
      busy      <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          out_valid <= 1'b0;
          plaintext <= 128'h0;
          if (in_valid && in_ready) begin
            state_reg <= ciphertext;
            rk_reg    <= key;
            rcnt      <= 4'd0;
            fsm_r     <= KEYEXP;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end else begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        KEYEXP: begin
          rk_reg <= rk_fwd_s;
          // The last expansion step also applies the initial AddRoundKey with the fresh K10.
          if (rcnt >= 4'd9) begin
            state_reg <= state_reg ^ rk_fwd_s;
            rcnt      <= 4'd10;
            fsm_r     <= ROUND;
          end else begin
            rcnt      <= rcnt + 4'd1;
          end
        end
        ROUND: begin
          rk_reg <= rk_rev_s;
          if (rcnt <= 4'd1) begin
            state_reg <= isb_s;
            plaintext <= isb_s;
            rcnt      <= 4'd0;
            fsm_r     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state_reg <= imc_s;
            rcnt      <= rcnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_r     <= IDLE;
            out_valid <= 1'b0;
            plaintext <= 128'h0;
            in_ready  <= 1'b1;
          end else begin
            out_valid <= 1'b1;
            plaintext <= state_reg;
          end
        end
        default: begin
          fsm_r     <= IDLE;
          rcnt      <= 4'd0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          plaintext <= 128'h0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_core
//   Scoreboard bench. The stimulus pushes the expected plaintext at each accept.
//   A negedge monitor pops and compares at every output handshake.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_core;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ciphertext = 128'h0;
  logic [127:0] key = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] plaintext;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_decrypt_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compare at each handshake; plaintext must read zero whenever out_valid is low.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h expected=<none>", plaintext);
        end else begin
          check("plaintext", plaintext, exp_q.pop_front());
        end
      end
    end else begin
      check("pt_zero_when_invalid", plaintext, 128'h0);
    end
  end

  // Called #1 after a posedge. Returns #1 after the accept edge, with the inputs scrambled.
  task automatic send(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 expected=1");
    end
    ciphertext = ct;
    key        = k;
    in_valid   = 1'b1;
    @(posedge clk);
    exp_q.push_back(pt);
    #1;
    in_valid   = 1'b0;
    ciphertext = ~ct;
    key        = ~k;
  endtask

  // The accept edge counts as edge 1; this counts edges up to the first out_valid cycle.
  task automatic wait_out(output int edges);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int edges;
    int seen;
    // Reset state while rst_n is asserted.
    #12;
    check("rst_in_ready", in_ready, 128'h0);
    check("rst_out_valid", out_valid, 128'h0);
    check("rst_busy", busy, 128'h0);
    check("rst_plaintext", plaintext, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 128'h1);

    // Vector A: latency, K10 probe after KEYEXP, key restored after ROUND.
    send(CT_A, KEY_A, PT_A);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 11) begin
        check("rk_after_keyexp", dut.rk_reg, K10_A);
        check("busy_in_round", busy, 128'h1);
        check("in_ready_busy", in_ready, 128'h0);
      end
    end
    check("latency_a", edges, 128'd21);
    check("rk_after_round", dut.rk_reg, KEY_A);
    @(posedge clk); #1;

    // Vector B.
    send(CT_B, KEY_B, PT_B);
    wait_out(edges);
    check("latency_b", edges, 128'd21);
    @(posedge clk); #1;

    // Stall in DONE for 5 cycles.
    out_ready = 1'b0;
    send(CT_A, KEY_A, PT_A);
    wait_out(edges);
    for (int i = 0; i < 5; i++) begin
      check("stall_plaintext", plaintext, PT_A);
      check("stall_out_valid", out_valid, 128'h1);
      check("stall_in_ready", in_ready, 128'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 128'h1);
    check("release_out_valid", out_valid, 128'h0);

    // in_valid pulsed with other data during ROUND must be ignored.
    send(CT_B, KEY_B, PT_B);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("busy_before_pulse", busy, 128'h1);
    ciphertext = CT_A;
    key        = KEY_A;
    in_valid   = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("pulse_in_ready", in_ready, 128'h0);
    end
    in_valid = 1'b0;
    wait_out(edges);
    check("ignore_out_valid", out_valid, 128'h1);
    @(posedge clk); #1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("no_second_block", seen, 128'h0);

    // Reset at ROUND rcnt=5, then a clean vector B.
    send(CT_A, KEY_A, PT_A);
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("rcnt_before_abort", dut.rcnt, 128'd5);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 128'h0);
    check("abort_in_ready", in_ready, 128'h0);
    check("abort_busy", busy, 128'h0);
    check("abort_plaintext", plaintext, 128'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_release_in_ready", in_ready, 128'h1);
    send(CT_B, KEY_B, PT_B);
    wait_out(edges);
    check("latency_after_abort", edges, 128'd21);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("scoreboard_empty", exp_q.size(), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
